// File: rtl/tfl_defs.sv
// Shared definitions for the two-road traffic-light controller:
// phase codes, lamp encodings and phase code width.
package tfl_defs;

   localparam int unsigned PHASE_W = 3;

   // EMERG only becomes reachable when TFL_EMERGENCY_EN is defined;
   // otherwise code 7 is treated as illegal and recovers to AR_A.
   typedef enum logic [PHASE_W-1:0] {
      AR_A  = 3'd0,
      GRN_A = 3'd1,
      YEL_A = 3'd2,
      AR_B  = 3'd3,
      GRN_B = 3'd4,
      YEL_B = 3'd5,
      PED   = 3'd6,
      EMERG = 3'd7
   } phase_e;

   // Lamp encodings, {red,yellow,green}
   localparam logic [2:0] LAMP_RED = 3'b100;
   localparam logic [2:0] LAMP_YEL = 3'b010;
   localparam logic [2:0] LAMP_GRN = 3'b001;

endpackage

// File: rtl/tfl_phase_timer.sv
// Restartable phase timer: counts cycles in the current phase and flags the
// last cycle of the programmed duration. A duration of 2^CNT_W arrives
// truncated to 0, and the modular subtract still yields the all-ones terminal.
module tfl_phase_timer #(
   parameter int unsigned CNT_W = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic [CNT_W-1:0] duration,
   output logic [CNT_W-1:0] cnt,
   output logic             done
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: restart on phase change, otherwise advance
   always_comb begin
      cnt_d = cnt_q + CNT_W'(1);
      if (clear) begin
         cnt_d = '0;
      end
   end

   // Count register, asynchronous reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt  = cnt_q;
   assign done = (cnt_q == duration - CNT_W'(1));

endmodule

// File: rtl/tfl_phase_controller.sv
// Two-road traffic-light phase sequencer with on-demand pedestrian phase.
// Optional emergency override is enabled by defining TFL_EMERGENCY_EN.
module tfl_phase_controller
   import tfl_defs::*;
#(
   parameter int unsigned GREEN_A  = 60,
   parameter int unsigned GREEN_B  = 50,
   parameter int unsigned YELLOW   = 5,
   parameter int unsigned ALL_RED  = 2,
   parameter int unsigned PED_WALK = 10,
   parameter int unsigned CNT_W    = 10
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               ped_req,
`ifdef TFL_EMERGENCY_EN
   input  logic               emerg,
`endif
   output logic [2:0]         light_a,
   output logic [2:0]         light_b,
   output logic               walk,
   output logic               ped_ack,
   output logic [PHASE_W-1:0] state_o,
   output logic [CNT_W-1:0]   phase_cnt
);

   localparam logic [CNT_W-1:0] DUR_GA  = CNT_W'(GREEN_A);
   localparam logic [CNT_W-1:0] DUR_GB  = CNT_W'(GREEN_B);
   localparam logic [CNT_W-1:0] DUR_Y   = CNT_W'(YELLOW);
   localparam logic [CNT_W-1:0] DUR_AR  = CNT_W'(ALL_RED);
   localparam logic [CNT_W-1:0] DUR_PED = CNT_W'(PED_WALK);

   phase_e           state_q, state_d;
   logic             pend_q, pend_d;
   logic [CNT_W-1:0] phase_dur;
   logic [CNT_W-1:0] cnt;
   logic             done;
   logic             clear;
   logic             emerg_w;

`ifdef TFL_EMERGENCY_EN
   assign emerg_w = emerg;
`else
   assign emerg_w = 1'b0;
`endif

   tfl_phase_timer #(
      .CNT_W(CNT_W)
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .clear    (clear),
      .duration (phase_dur),
      .cnt      (cnt),
      .done     (done)
   );

   // Phase duration select, next phase, pedestrian latch and timer restart
   always_comb begin
      state_d   = state_q;
      pend_d    = pend_q | ped_req;
      phase_dur = DUR_AR;
      case (state_q)
         AR_A: begin
            phase_dur = DUR_AR;
            if (done) state_d = GRN_A;
         end
         GRN_A: begin
            phase_dur = DUR_GA;
            if (done || emerg_w) state_d = YEL_A;
         end
         YEL_A: begin
            phase_dur = DUR_Y;
            if (done) state_d = emerg_w ? EMERG : AR_B;
         end
         AR_B: begin
            phase_dur = DUR_AR;
            if (done) state_d = GRN_B;
         end
         GRN_B: begin
            phase_dur = DUR_GB;
            if (done || emerg_w) state_d = YEL_B;
         end
         YEL_B: begin
            phase_dur = DUR_Y;
            if (done) begin
               if (emerg_w)     state_d = EMERG;
               else if (pend_q) state_d = PED;
               else             state_d = AR_A;
            end
         end
         PED: begin
            phase_dur = DUR_PED;
            if (done) state_d = emerg_w ? EMERG : AR_A;
         end
`ifdef TFL_EMERGENCY_EN
         EMERG: begin
            if (!emerg_w) state_d = AR_A;
         end
`endif
         default: state_d = AR_A;
      endcase
      // Entering PED serves the request, including one sampled on this edge
      if (state_q == YEL_B && state_d == PED) begin
         pend_d = 1'b0;
      end
      // EMERG keeps the timer parked at 0 so an indefinite hold cannot wrap it
      clear = (state_d != state_q) || (state_q == EMERG);
   end

   // Phase and pending-request registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= AR_A;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
      end
   end

   // Moore lamp decode from registered phase
   always_comb begin
      light_a = LAMP_RED;
      light_b = LAMP_RED;
      walk    = 1'b0;
      case (state_q)
         GRN_A:   light_a = LAMP_GRN;
         YEL_A:   light_a = LAMP_YEL;
         GRN_B:   light_b = LAMP_GRN;
         YEL_B:   light_b = LAMP_YEL;
         PED:     walk    = 1'b1;
         default: ;
      endcase
   end

   assign ped_ack   = (state_q == PED) && (cnt == '0);
   assign state_o   = state_q;
   assign phase_cnt = cnt;

endmodule

// File: doc/tfl_phase_controller.md
Name: tfl_phase_controller

Overview:
Two-road traffic-light sequencer for the smart TFL design. Steps through fixed phases (all-red, green, yellow for road A then road B) plus an on-demand pedestrian walk phase. Owns a restartable phase timer that clears on every phase change, so each phase duration is exact. Drives lamp outputs for both roads and the walk signal.

Parameters:
GREEN_A, 60, green duration for road A in clk cycles (≥1)
GREEN_B, 50, green duration for road B in clk cycles (≥1)
YELLOW, 5, yellow duration for either road (≥1)
ALL_RED, 2, all-red clearance duration (≥1)
PED_WALK, 10, pedestrian walk duration (≥1)
CNT_W, 10, phase counter width; every duration must be ≤ 2^CNT_W

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
ped_req  in  1  pedestrian button; level or pulse, sampled every cycle
light_a  out  3  road A lamps {red,yellow,green}, one-hot
light_b  out  3  road B lamps {red,yellow,green}, one-hot
walk  out  1  pedestrian walk lamp
ped_ack  out  1  one-cycle pulse when a pending request is served
state_o  out  3  current phase code, for debug/monitoring
phase_cnt  out  CNT_W  cycles elapsed in current phase

Behaviour:
- Reset: clock clk; reset is asynchronous, active-high. Reset forces state=AR_A (code 0), cnt=0, ped_pending=0. Outputs during and immediately after reset: light_a=100, light_b=100, walk=0, ped_ack=0, state_o=0, phase_cnt=0.
- Phase codes and durations: AR_A=0 (ALL_RED), GRN_A=1 (GREEN_A), YEL_A=2 (YELLOW), AR_B=3 (ALL_RED), GRN_B=4 (GREEN_B), YEL_B=5 (YELLOW), PED=6 (PED_WALK). Code 7 is illegal and recovers to AR_A on the next clock.
- Transition order: AR_A->GRN_A->YEL_A->AR_B->GRN_B->YEL_B. YEL_B goes to PED if ped_pending=1, otherwise to AR_A. PED always goes to AR_A.
- Timer: cnt increments each cycle. Terminal condition is cnt==dur-1 for the current phase. On terminal, the state advances and cnt loads 0 on the same edge. Each phase therefore lasts exactly dur cycles, and cnt never wraps.
- Lamp decode (Moore, from registered state only):
  - GRN_A: A=001, B=100
  - YEL_A: A=010, B=100
  - GRN_B: A=100, B=001
  - YEL_B: A=100, B=010
  - AR_A, AR_B, PED: both 100
  - walk=1 only in PED.
- Safety invariant: light_a and light_b are never both non-red. Walk=1 implies both roads are red.
- Pedestrian request:
  - ped_req=1 sets ped_pending on the next edge.
  - On the YEL_B->PED edge, ped_pending clears and ped_ack is high for exactly the first PED cycle.
  - A ped_req sampled on that same edge is treated as served and is not re-latched.
  - A ped_req during PED or later sets ped_pending again, to be served in the next cycle.
  - ped_pending set during YEL_B's terminal cycle is not seen; the transition uses the registered value.
- Reset mid-phase: immediate return to AR_A with all outputs at reset values. Any pending request is discarded.
- Full cycle length: without pedestrian phase = 2·ALL_RED + GREEN_A + GREEN_B + 2·YELLOW. With pedestrian phase, add PED_WALK.

Optional Feature:
TFL_EMERGENCY_EN:
- When defined, adds input port emerg (1 bit) and phase EMERG (code 7 instead of illegal).
- emerg=1 in GRN_A or GRN_B cuts the green short: next state is YEL_A or YEL_B, with cnt cleared.
- At the end of any yellow or PED phase while emerg=1, go to EMERG: all lamps red, walk=0.
- EMERG holds while emerg=1. On emerg=0, go to AR_A with cnt=0.
- ped_pending is preserved across EMERG.
- When undefined: no emerg port, and code 7 is recovered as illegal.

Decomposition:
- Shared include/package tfl_defs: phase code localparams, lamp encodings (RED=3'b100, YEL=3'b010, GRN=3'b001), and phase code width.
- One sub-module, tfl_phase_timer:
  - Inputs: clear, duration[CNT_W-1:0].
  - Outputs: cnt, done (cnt==duration-1).
  - Async reset to 0.
- The controller muxes duration from state and drives clear on transition.

Test Plan:
Tests use GREEN_A=4, GREEN_B=3, YELLOW=2, ALL_RED=1, PED_WALK=3.
1. Reset asserted mid-GRN_B -> same-cycle outputs A=100, B=100, walk=0, state_o=0, phase_cnt=0. After release, AR_A lasts 1 cycle, then GRN_A.
2. Free run, no ped_req -> state sequence 0,1,1,1,1,2,2,3,4,4,4,5,5,0 (13-cycle period). Checker confirms A and B are never simultaneously non-red.
3. Single-cycle ped_req during GRN_A -> after YEL_B, PED lasts 3 cycles with walk=1 and both roads red. ped_ack is high on the first PED cycle only, then AR_A. Period is 16 cycles.
4. ped_req held high continuously -> PED is entered every cycle. ped_ack pulses once per PED phase. No consecutive PED phases.
5. ped_req pulse during PED -> next cycle runs the full A/B sequence, then PED again. A pulse on the YEL_B->PED edge alone produces no extra PED in the following cycle.
6. (TFL_EMERGENCY_EN) emerg=1 at GRN_A cnt=1 -> YEL_A for 2 cycles, then EMERG with all red. Hold 5 cycles, release -> AR_A. A pending ped_req is still served at the next YEL_B.
